// File: rtl/ddram_arbiter.sv
// Two-requester (MCR/SDRAM) arbiter onto a single-beat 64-bit DDRAM port; grant-to-done 3 cycles for writes, 3 + read latency for reads.
// DDRAM_BUSY holds the command stable in ISSUE; requesters hold req until their done pulse.
module ddram_arbiter #(
   parameter logic [28:0] MCR_BASE   = 29'h0000000,
   parameter logic [28:0] SDRAM_BASE = 29'h0100000,
   parameter int          STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [13:0] mcr_addr,
   input  logic [48:0] mcr_data_in,
   output logic [48:0] mcr_data_out,
   input  logic        mcr_req,
   input  logic        mcr_write,
   output logic        mcr_done,
   input  logic [21:0] sdram_addr,
   input  logic [31:0] sdram_data_in,
   output logic [31:0] sdram_data_out,
   input  logic        sdram_req,
   input  logic        sdram_write,
   output logic        sdram_done,
   input  logic        DDRAM_BUSY,
   output logic [7:0]  DDRAM_BURSTCNT,
   output logic [28:0] DDRAM_ADDR,
   output logic [63:0] DDRAM_DIN,
   output logic [7:0]  DDRAM_BE,
   output logic        DDRAM_WE,
   output logic        DDRAM_RD,
   input  logic [63:0] DDRAM_DOUT,
   input  logic        DDRAM_DOUT_READY
);

   localparam int            CW         = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

   state_t        state, state_nxt;
   logic          gnt_sd, gnt_wr, gnt_hi;
   logic [28:0]   cmd_addr;
   logic [63:0]   cmd_din;
   logic [7:0]    cmd_be;
   logic [CW-1:0] starve_cnt;
   logic          mask_mcr, mask_sd;
   logic          grant_mcr, grant_sd;

   // Priority is decided first; a winner whose done pulsed last cycle is then
   // suppressed, since its req may still be the stale one from that transaction.
   always_comb begin
      grant_mcr = 1'b0;
      grant_sd  = 1'b0;
      if (state == IDLE) begin
         if (starve_cnt == STARVE_LIM && sdram_req)
            grant_sd = !mask_sd;
         else if (mcr_req)
            grant_mcr = !mask_mcr;
         else if (sdram_req)
            grant_sd = !mask_sd;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_mcr || grant_sd) state_nxt = ISSUE;
         ISSUE:   if (!DDRAM_BUSY) state_nxt = gnt_wr ? DONE : WAIT_RD;
         WAIT_RD: if (DDRAM_DOUT_READY) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      DDRAM_WE   = 1'b0;
      DDRAM_RD   = 1'b0;
      DDRAM_ADDR = '0;
      DDRAM_DIN  = '0;
      DDRAM_BE   = '0;
      mcr_done   = 1'b0;
      sdram_done = 1'b0;
      if (state == ISSUE) begin
         DDRAM_WE   = gnt_wr;
         DDRAM_RD   = !gnt_wr;
         DDRAM_ADDR = cmd_addr;
         DDRAM_DIN  = cmd_din;
         DDRAM_BE   = cmd_be;
      end
      if (state == DONE) begin
         mcr_done   = !gnt_sd;
         sdram_done = gnt_sd;
      end
   end

   assign DDRAM_BURSTCNT = 8'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gnt_sd         <= 1'b0;
         gnt_wr         <= 1'b0;
         gnt_hi         <= 1'b0;
         cmd_addr       <= '0;
         cmd_din        <= '0;
         cmd_be         <= '0;
         starve_cnt     <= '0;
         mask_mcr       <= 1'b0;
         mask_sd        <= 1'b0;
         mcr_data_out   <= '0;
         sdram_data_out <= '0;
      end else begin
         mask_mcr <= mcr_done;
         mask_sd  <= sdram_done;

         if (grant_mcr) begin
            gnt_sd   <= 1'b0;
            gnt_wr   <= mcr_write;
            gnt_hi   <= 1'b0;
            cmd_addr <= MCR_BASE + {15'b0, mcr_addr};
            cmd_din  <= {15'b0, mcr_data_in};
            cmd_be   <= 8'hFF;
         end else if (grant_sd) begin
            gnt_sd   <= 1'b1;
            gnt_wr   <= sdram_write;
            gnt_hi   <= sdram_addr[0];
            cmd_addr <= SDRAM_BASE + {8'b0, sdram_addr[21:1]};
            cmd_din  <= {sdram_data_in, sdram_data_in};
            cmd_be   <= sdram_addr[0] ? 8'hF0 : 8'h0F;
         end

         if (!sdram_req || grant_sd)
            starve_cnt <= '0;
         else if (grant_mcr && starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + CW'(1);

         // Only READY seen in WAIT_RD belongs to our command.
         if (state == WAIT_RD && DDRAM_DOUT_READY) begin
            if (gnt_sd)
               sdram_data_out <= gnt_hi ? DDRAM_DOUT[63:32] : DDRAM_DOUT[31:0];
            else
               mcr_data_out <= DDRAM_DOUT[48:0];
         end
      end
   end

endmodule

// File: tb/tb_ddram_arbiter.sv
// Directed bench for ddram_arbiter: a small DDRAM responder with configurable read latency
// backs the port, and each scenario task compares observations against hand-computed values.
module tb_ddram_arbiter;

   localparam logic [28:0] MCR_BASE   = 29'h0000000;
   localparam logic [28:0] SDRAM_BASE = 29'h0100000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [13:0] mcr_addr = '0;
   logic [48:0] mcr_data_in = '0;
   logic [48:0] mcr_data_out;
   logic        mcr_req = 1'b0;
   logic        mcr_write = 1'b0;
   logic        mcr_done;
   logic [21:0] sdram_addr = '0;
   logic [31:0] sdram_data_in = '0;
   logic [31:0] sdram_data_out;
   logic        sdram_req = 1'b0;
   logic        sdram_write = 1'b0;
   logic        sdram_done;
   logic        DDRAM_BUSY = 1'b0;
   logic [7:0]  DDRAM_BURSTCNT;
   logic [28:0] DDRAM_ADDR;
   logic [63:0] DDRAM_DIN;
   logic [7:0]  DDRAM_BE;
   logic        DDRAM_WE;
   logic        DDRAM_RD;
   logic [63:0] DDRAM_DOUT = '0;
   logic        DDRAM_DOUT_READY = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ddram_arbiter #(
      .MCR_BASE  (MCR_BASE),
      .SDRAM_BASE(SDRAM_BASE),
      .STARVE_MAX(4)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .mcr_addr        (mcr_addr),
      .mcr_data_in     (mcr_data_in),
      .mcr_data_out    (mcr_data_out),
      .mcr_req         (mcr_req),
      .mcr_write       (mcr_write),
      .mcr_done        (mcr_done),
      .sdram_addr      (sdram_addr),
      .sdram_data_in   (sdram_data_in),
      .sdram_data_out  (sdram_data_out),
      .sdram_req       (sdram_req),
      .sdram_write     (sdram_write),
      .sdram_done      (sdram_done),
      .DDRAM_BUSY      (DDRAM_BUSY),
      .DDRAM_BURSTCNT  (DDRAM_BURSTCNT),
      .DDRAM_ADDR      (DDRAM_ADDR),
      .DDRAM_DIN       (DDRAM_DIN),
      .DDRAM_BE        (DDRAM_BE),
      .DDRAM_WE        (DDRAM_WE),
      .DDRAM_RD        (DDRAM_RD),
      .DDRAM_DOUT      (DDRAM_DOUT),
      .DDRAM_DOUT_READY(DDRAM_DOUT_READY)
   );

   // DDRAM responder: a command seen at the falling edge with BUSY low is accepted
   // by the next rising edge; read data returns rd_lat cycles after acceptance.
   logic [63:0] mem [int];
   logic [63:0] rd_data = '0;
   logic [63:0] wr_word;
   int          rd_cnt = 0;
   int          rd_lat = 2;
   bit          glitch = 1'b0;
   int          accepts = 0;
   logic [28:0] cmd_addr = '0;
   logic [7:0]  cmd_be = '0;
   logic [63:0] cmd_din = '0;
   logic        cmd_we = 1'b0;

   always @(negedge clk) begin
      DDRAM_DOUT_READY = 1'b0;
      if (rd_cnt > 0) begin
         rd_cnt = rd_cnt - 1;
         if (rd_cnt == 0) begin
            DDRAM_DOUT_READY = 1'b1;
            DDRAM_DOUT       = rd_data;
         end
      end
      if ((DDRAM_WE || DDRAM_RD) && !DDRAM_BUSY && reset_n) begin
         accepts  = accepts + 1;
         cmd_addr = DDRAM_ADDR;
         cmd_be   = DDRAM_BE;
         cmd_din  = DDRAM_DIN;
         cmd_we   = DDRAM_WE;
         if (DDRAM_WE) begin
            wr_word = mem.exists(int'(DDRAM_ADDR)) ? mem[int'(DDRAM_ADDR)] : 64'h0;
            for (int b = 0; b < 8; b++)
               if (DDRAM_BE[b]) wr_word[b*8 +: 8] = DDRAM_DIN[b*8 +: 8];
            mem[int'(DDRAM_ADDR)] = wr_word;
         end else begin
            rd_data = mem.exists(int'(DDRAM_ADDR)) ? mem[int'(DDRAM_ADDR)] : 64'h0;
            rd_cnt  = rd_lat;
            if (glitch) begin
               DDRAM_DOUT_READY = 1'b1;
               DDRAM_DOUT       = 64'hDEAD_BEEF_DEAD_BEEF;
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Runs one transaction; lat counts cycles from req presentation to the done cycle
   // inclusive (-1 on timeout); still is done sampled one cycle after the pulse.
   task automatic txn(input bit sd, input bit wr, input logic [21:0] a, input logic [48:0] d,
                      output logic [48:0] rdata, output int lat, output logic still);
      bit got;
      got   = 1'b0;
      lat   = 1;
      rdata = '0;
      if (sd) begin
         sdram_req = 1'b1; sdram_write = wr; sdram_addr = a; sdram_data_in = d[31:0];
      end else begin
         mcr_req = 1'b1; mcr_write = wr; mcr_addr = a[13:0]; mcr_data_in = d;
      end
      for (int i = 0; i < 60 && !got; i++) begin
         tick;
         lat++;
         if (sd ? sdram_done : mcr_done) begin
            got   = 1'b1;
            rdata = sd ? {17'b0, sdram_data_out} : mcr_data_out;
         end
      end
      if (!got) lat = -1;
      mcr_req   = 1'b0;
      sdram_req = 1'b0;
      tick;
      still = sd ? sdram_done : mcr_done;
      tick;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      tick; tick;
      checks++; if ({DDRAM_WE, DDRAM_RD} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {DDRAM_WE, DDRAM_RD}); end
      checks++; if (DDRAM_ADDR !== 29'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", DDRAM_ADDR); end
      checks++; if (DDRAM_DIN !== 64'h0) begin errors++; $display("FAIL reset_din: got %h want 0", DDRAM_DIN); end
      checks++; if (DDRAM_BE !== 8'h0) begin errors++; $display("FAIL reset_be: got %h want 0", DDRAM_BE); end
      checks++; if ({mcr_done, sdram_done} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", {mcr_done, sdram_done}); end
      checks++; if (mcr_data_out !== 49'h0) begin errors++; $display("FAIL reset_mcr_data: got %h want 0", mcr_data_out); end
      checks++; if (sdram_data_out !== 32'h0) begin errors++; $display("FAIL reset_sdram_data: got %h want 0", sdram_data_out); end
      checks++; if (DDRAM_BURSTCNT !== 8'd1) begin errors++; $display("FAIL reset_burstcnt: got %0d want 1", DDRAM_BURSTCNT); end
      reset_n = 1'b1;
      tick; tick;
   endtask

   task automatic test_mcr;
      logic [48:0] rd;
      int          lat;
      logic        still;
      txn(1'b0, 1'b1, 22'h3, 49'o111100001111, rd, lat, still);
      checks++; if (lat !== 3) begin errors++; $display("FAIL mcr_wr_latency: got %0d want 3", lat); end
      checks++; if (cmd_addr !== MCR_BASE + 29'd3) begin errors++; $display("FAIL mcr_wr_addr: got %h want %h", cmd_addr, MCR_BASE + 29'd3); end
      checks++; if (cmd_be !== 8'hFF) begin errors++; $display("FAIL mcr_wr_be: got %h want ff", cmd_be); end
      checks++; if (cmd_din !== {15'b0, 49'o111100001111}) begin errors++; $display("FAIL mcr_wr_din: got %h want %h", cmd_din, {15'b0, 49'o111100001111}); end
      checks++; if (cmd_we !== 1'b1) begin errors++; $display("FAIL mcr_wr_we: got %b want 1", cmd_we); end
      checks++; if (still !== 1'b0) begin errors++; $display("FAIL mcr_wr_done_width: done still %b one cycle later, want 0", still); end
      txn(1'b0, 1'b0, 22'h3, 49'h0, rd, lat, still);
      checks++; if (lat !== 5) begin errors++; $display("FAIL mcr_rd_latency: got %0d want 5", lat); end
      checks++; if (cmd_addr !== MCR_BASE + 29'd3) begin errors++; $display("FAIL mcr_rd_addr: got %h want %h", cmd_addr, MCR_BASE + 29'd3); end
      checks++; if ({cmd_we, cmd_be} !== {1'b0, 8'hFF}) begin errors++; $display("FAIL mcr_rd_cmd: got we=%b be=%h want we=0 be=ff", cmd_we, cmd_be); end
      checks++; if (rd !== 49'o111100001111) begin errors++; $display("FAIL mcr_rd_data: got %o want 111100001111", rd); end
      checks++; if (still !== 1'b0) begin errors++; $display("FAIL mcr_rd_done_width: done still %b one cycle later, want 0", still); end
   endtask

   task automatic test_sdram;
      logic [48:0] rd;
      int          lat;
      logic        still;
      txn(1'b1, 1'b1, 22'h1, {17'b0, 32'o10101111}, rd, lat, still);
      checks++; if ({cmd_addr, cmd_be} !== {SDRAM_BASE, 8'hF0}) begin errors++; $display("FAIL sd_wr1_cmd: got addr=%h be=%h want addr=%h be=f0", cmd_addr, cmd_be, SDRAM_BASE); end
      checks++; if (cmd_din !== {32'o10101111, 32'o10101111}) begin errors++; $display("FAIL sd_wr1_din: got %h want %h", cmd_din, {32'o10101111, 32'o10101111}); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL sd_wr1_latency: got %0d want 3", lat); end
      txn(1'b1, 1'b1, 22'h0, 49'h0, rd, lat, still);
      checks++; if ({cmd_addr, cmd_be} !== {SDRAM_BASE, 8'h0F}) begin errors++; $display("FAIL sd_wr0_cmd: got addr=%h be=%h want addr=%h be=0f", cmd_addr, cmd_be, SDRAM_BASE); end
      txn(1'b1, 1'b0, 22'h1, 49'h0, rd, lat, still);
      checks++; if ({cmd_addr, cmd_be, cmd_we} !== {SDRAM_BASE, 8'hF0, 1'b0}) begin errors++; $display("FAIL sd_rd1_cmd: got addr=%h be=%h we=%b", cmd_addr, cmd_be, cmd_we); end
      checks++; if (rd[31:0] !== 32'o10101111) begin errors++; $display("FAIL sd_rd1_data: got %o want 10101111", rd[31:0]); end
      checks++; if (lat !== 5) begin errors++; $display("FAIL sd_rd1_latency: got %0d want 5", lat); end
      txn(1'b1, 1'b0, 22'h0, 49'h0, rd, lat, still);
      checks++; if ({cmd_addr, cmd_be} !== {SDRAM_BASE, 8'h0F}) begin errors++; $display("FAIL sd_rd0_cmd: got addr=%h be=%h want be=0f", cmd_addr, cmd_be); end
      checks++; if (rd[31:0] !== 32'h0) begin errors++; $display("FAIL sd_rd0_data: got %h want 0", rd[31:0]); end
      txn(1'b1, 1'b1, 22'h3FFFFF, {17'b0, 32'h1234_5678}, rd, lat, still);
      checks++; if ({cmd_addr, cmd_be} !== {29'h02FFFFF, 8'hF0}) begin errors++; $display("FAIL sd_top_cmd: got addr=%h be=%h want addr=02fffff be=f0", cmd_addr, cmd_be); end
      checks++; if (mcr_data_out !== 49'o111100001111) begin errors++; $display("FAIL mcr_data_hold: got %o want 111100001111", mcr_data_out); end
   endtask

   task automatic test_busy_stall;
      int acc0;
      bit seen;
      seen = 1'b0;
      DDRAM_BUSY = 1'b1;
      acc0 = accepts;
      sdram_req = 1'b1; sdram_write = 1'b1; sdram_addr = 22'h6; sdram_data_in = 32'hA5A5_5A5A;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick;
         seen = DDRAM_WE;
      end
      checks++; if (!seen) begin errors++; $display("FAIL busy_strobe_timeout: WE never rose within 10 cycles"); end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if ({DDRAM_WE, DDRAM_RD, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, sdram_done} !==
             {1'b1, 1'b0, SDRAM_BASE + 29'd3, {2{32'hA5A5_5A5A}}, 8'h0F, 1'b0}) begin
            errors++;
            $display("FAIL busy_hold_%0d: got we=%b rd=%b addr=%h din=%h be=%h done=%b", k,
                     DDRAM_WE, DDRAM_RD, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, sdram_done);
         end
         if (k < 4) tick;
      end
      DDRAM_BUSY = 1'b0;
      tick;
      checks++; if ({sdram_done, DDRAM_WE} !== 2'b10) begin errors++; $display("FAIL busy_release: got done=%b we=%b want done=1 we=0", sdram_done, DDRAM_WE); end
      sdram_req = 1'b0;
      tick; tick;
      checks++; if (accepts - acc0 !== 1) begin errors++; $display("FAIL busy_accepts: got %0d want 1", accepts - acc0); end
   endtask

   task automatic test_ready_at_accept;
      logic [48:0] rd;
      int          lat;
      logic        still;
      glitch = 1'b1;
      txn(1'b0, 1'b0, 22'h3, 49'h0, rd, lat, still);
      glitch = 1'b0;
      checks++; if (rd !== 49'o111100001111) begin errors++; $display("FAIL early_ready_data: got %h want %h", rd, 49'o111100001111); end
      checks++; if (lat !== 5) begin errors++; $display("FAIL early_ready_latency: got %0d want 5", lat); end
   endtask

   task automatic test_starve;
      bit exp_sd [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      bit got_sd [10];
      int n;
      n = 0;
      mcr_req = 1'b1; mcr_write = 1'b1; mcr_addr = 14'h10; mcr_data_in = 49'h1_2345;
      sdram_req = 1'b1; sdram_write = 1'b1; sdram_addr = 22'h10; sdram_data_in = 32'h6789;
      for (int c = 0; c < 300 && n < 10; c++) begin
         tick;
         if (mcr_done) begin got_sd[n] = 1'b0; n++; end
         else if (sdram_done) begin got_sd[n] = 1'b1; n++; end
      end
      mcr_req = 1'b0; sdram_req = 1'b0;
      tick; tick;
      checks++; if (n !== 10) begin errors++; $display("FAIL starve_timeout: got %0d grants want 10", n); end
      for (int i = 0; i < n; i++) begin
         checks++;
         if (got_sd[i] !== exp_sd[i]) begin
            errors++;
            $display("FAIL starve_order_%0d: got %s want %s", i, got_sd[i] ? "S" : "M", exp_sd[i] ? "S" : "M");
         end
      end
   endtask

   task automatic test_simultaneous;
      int m_at, s_at;
      m_at = -1; s_at = -1;
      mcr_req = 1'b1; mcr_write = 1'b1; mcr_addr = 14'h5; mcr_data_in = 49'h1;
      sdram_req = 1'b1; sdram_write = 1'b1; sdram_addr = 22'h4; sdram_data_in = 32'h2;
      for (int c = 1; c <= 40 && s_at < 0; c++) begin
         tick;
         if (mcr_done && m_at < 0) begin m_at = c; mcr_req = 1'b0; end
         if (sdram_done && s_at < 0) begin s_at = c; sdram_req = 1'b0; end
      end
      mcr_req = 1'b0; sdram_req = 1'b0;
      tick; tick;
      checks++; if (m_at !== 2) begin errors++; $display("FAIL simul_mcr_done_cycle: got %0d want 2", m_at); end
      checks++; if (s_at !== 5) begin errors++; $display("FAIL simul_sdram_done_cycle: got %0d want 5", s_at); end
   endtask

   task automatic test_reset_wait_rd;
      logic [48:0] rd;
      int          lat;
      logic        still;
      bit          seen, stray;
      seen = 1'b0; stray = 1'b0;
      rd_lat = 6;
      sdram_req = 1'b1; sdram_write = 1'b0; sdram_addr = 22'h0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick;
         seen = DDRAM_RD;
      end
      tick;
      checks++; if ({seen, DDRAM_RD} !== 2'b10) begin errors++; $display("FAIL rst_enter_wait: seen=%b rd=%b want seen=1 rd=0", seen, DDRAM_RD); end
      reset_n = 1'b0;
      sdram_req = 1'b0;
      #2;
      checks++;
      if ({DDRAM_WE, DDRAM_RD, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, mcr_done, sdram_done, mcr_data_out, sdram_data_out} !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs: we=%b rd=%b addr=%h be=%h mdone=%b sdone=%b mdat=%h sdat=%h",
                  DDRAM_WE, DDRAM_RD, DDRAM_ADDR, DDRAM_BE, mcr_done, sdram_done, mcr_data_out, sdram_data_out);
      end
      tick;
      reset_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick;
         if (mcr_done || sdram_done || DDRAM_WE || DDRAM_RD) stray = 1'b1;
      end
      checks++; if (stray !== 1'b0) begin errors++; $display("FAIL rst_stray_activity: got activity=1 want 0"); end
      checks++; if (sdram_data_out !== 32'h0) begin errors++; $display("FAIL rst_stray_data: got %h want 0", sdram_data_out); end
      rd_lat = 2;
      txn(1'b1, 1'b0, 22'h1, 49'h0, rd, lat, still);
      checks++; if (rd[31:0] !== 32'o10101111) begin errors++; $display("FAIL rst_next_rd_data: got %o want 10101111", rd[31:0]); end
      checks++; if (lat !== 5) begin errors++; $display("FAIL rst_next_rd_latency: got %0d want 5", lat); end
   endtask

   initial begin
      test_reset;
      test_mcr;
      test_sdram;
      test_busy_stall;
      test_ready_at_accept;
      test_starve;
      test_simultaneous;
      test_reset_wait_rd;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/ddram_arbiter.md
Name: ddram_arbiter

Overview:
- Shares the single 64-bit DDRAM user port between the microcode-RAM requester (MCR, 49-bit words) and the main-memory requester (SDRAM, 32-bit words).
- Arbitrates between the two, maps each requester's address into its own DDRAM region, and issues one single-beat read or write at a time.
- Sits between the CPU-side memory ports and the DDRAM controller, in the CPU clock domain.

Parameters:
- MCR_BASE, 29'h0000000, DDRAM 64-bit word address of MCR word 0.
- SDRAM_BASE, 29'h0100000, DDRAM 64-bit word address of SDRAM words 0/1.
- STARVE_MAX, 4, maximum consecutive MCR grants while SDRAM is pending.

Ports:
clk  in  1  CPU-domain clock
reset_n  in  1  asynchronous active-low reset
mcr_addr  in  14  MCR word address
mcr_data_in  in  49  MCR write data
mcr_data_out  out  49  MCR read data, valid while mcr_done=1
mcr_req  in  1  MCR request, held until mcr_done
mcr_write  in  1  1=write, 0=read; sampled at grant
mcr_done  out  1  one-cycle completion pulse
sdram_addr  in  22  SDRAM 32-bit word address
sdram_data_in  in  32  SDRAM write data
sdram_data_out  out  32  SDRAM read data, valid while sdram_done=1
sdram_req  in  1  SDRAM request, held until sdram_done
sdram_write  in  1  1=write, 0=read; sampled at grant
sdram_done  out  1  one-cycle completion pulse
DDRAM_BUSY  in  1  controller stall
DDRAM_BURSTCNT  out  8  burst length, constant 1
DDRAM_ADDR  out  29  64-bit word address
DDRAM_DIN  out  64  write data
DDRAM_BE  out  8  byte enables
DDRAM_WE  out  1  write strobe
DDRAM_RD  out  1  read strobe
DDRAM_DOUT  in  64  read data
DDRAM_DOUT_READY  in  1  read data valid

Behaviour:
- Reset (async, reset_n=0): state IDLE; starve count 0; all outputs 0 except DDRAM_BURSTCNT=1. Any in-flight read is abandoned, and a DDRAM_DOUT_READY arriving after reset is ignored.
- States: IDLE -> ISSUE -> (write) DONE, or (read) WAIT_RD -> DONE; DONE -> IDLE.
- IDLE grant rule:
  - SDRAM is granted if starve count = STARVE_MAX and sdram_req=1.
  - Otherwise MCR is granted if mcr_req=1.
  - Otherwise SDRAM is granted if sdram_req=1.
  - A requester whose done pulsed in the previous cycle is masked for that cycle.
- Starve count: +1 on each MCR grant while sdram_req=1; cleared on any SDRAM grant or when sdram_req=0. Saturates at STARVE_MAX.
- On grant: latch requester id, address, write flag and data; go to ISSUE.
- MCR mapping:
  - DDRAM_ADDR = MCR_BASE + mcr_addr (zero-extended).
  - DDRAM_DIN = {15'b0, mcr_data_in}.
  - DDRAM_BE = 8'hFF.
  - Read data: mcr_data_out = DDRAM_DOUT[48:0].
- SDRAM mapping:
  - DDRAM_ADDR = SDRAM_BASE + sdram_addr[21:1].
  - DDRAM_DIN = {data, data}.
  - DDRAM_BE = sdram_addr[0] ? 8'hF0 : 8'h0F.
  - Read data: sdram_data_out = sdram_addr[0] ? DOUT[63:32] : DOUT[31:0].
- ISSUE: DDRAM_WE or DDRAM_RD is asserted together with ADDR/DIN/BE. The command is accepted on the first rising edge with DDRAM_BUSY=0; strobe, address and data are held stable while BUSY=1.
  - Write accepted -> DONE.
  - Read accepted -> WAIT_RD, strobe deasserted.
- WAIT_RD: waits any number of cycles for DDRAM_DOUT_READY=1, then registers the lane-selected data into the granted requester's data_out and goes to DONE. If DOUT_READY coincides with the accepting edge, the data is discarded; only READY seen in WAIT_RD counts.
- DONE: the granted requester's done=1 for exactly one cycle, with data_out stable. data_out holds its value until the next read by that requester.
- Minimum latency, grant to done with BUSY=0:
  - Write: 3 cycles (IDLE sample, ISSUE, DONE).
  - Read: 3 cycles + DDRAM read latency.
- req dropped mid-transaction: the transaction still completes and done still pulses. The requester must ignore the pulse.
- mcr_write/sdram_write changing after grant: no effect.
- Only one DDRAM command is ever outstanding.

Test Plan:
- MCR write @14'h0003 = 49'o111100001111, then read @3 -> DDRAM_ADDR=MCR_BASE+3, BE=8'hFF; mcr_done one cycle; mcr_data_out=49'o111100001111.
- SDRAM write @1 = 32'o10101111 and @0 = 32'o0, then read @1 and @0 -> both hit DDRAM_ADDR=SDRAM_BASE with BE F0 then 0F; reads return 32'o10101111 and 0.
- DDRAM_BUSY held for 5 cycles during ISSUE -> strobe, ADDR and DIN stable throughout; exactly one command accepted; done 1 cycle after BUSY falls.
- mcr_req and sdram_req held continuously (requesters re-request immediately) -> grant order M,M,M,M,S,M,M,M,M,S.
- reset_n pulsed low during WAIT_RD, then DOUT_READY=1 -> no done pulse; all outputs 0; next SDRAM read completes normally.
- Simultaneous mcr_req and sdram_req with starve count 0 -> MCR granted first; SDRAM done follows the MCR done.
